// File: rtl/controller_sequencer_pkg.sv
// Shared constants for the bus-machine controller: opcodes, ring-state indices,
// control-word bit positions and the per-state strobe decode.
package controller_sequencer_pkg;

    typedef enum logic [3:0] {
        OP_LDA = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_e;

    localparam int unsigned T1 = 0;
    localparam int unsigned T2 = 1;
    localparam int unsigned T3 = 2;
    localparam int unsigned T4 = 3;
    localparam int unsigned T5 = 4;
    localparam int unsigned T6 = 5;

    localparam int unsigned CW_CP = 0;
    localparam int unsigned CW_EP = 1;
    localparam int unsigned CW_LM = 2;
    localparam int unsigned CW_CE = 3;
    localparam int unsigned CW_LI = 4;
    localparam int unsigned CW_EI = 5;
    localparam int unsigned CW_LA = 6;
    localparam int unsigned CW_EA = 7;
    localparam int unsigned CW_SU = 8;
    localparam int unsigned CW_EU = 9;
    localparam int unsigned CW_LB = 10;
    localparam int unsigned CW_LO = 11;
    localparam int unsigned CW_W  = 12;

    // T1 strobes are suppressed when idling with run low.
    function automatic logic [CW_W-1:0] cw_decode(input logic [5:0] t,
                                                  input logic [3:0] op,
                                                  input logic       run);
        logic [CW_W-1:0] cw;
        cw = '0;
        if (t[T1] && run) begin
            cw[CW_EP] = 1'b1;
            cw[CW_LM] = 1'b1;
        end
        if (t[T2]) cw[CW_CP] = 1'b1;
        if (t[T3]) begin
            cw[CW_CE] = 1'b1;
            cw[CW_LI] = 1'b1;
        end
        if (t[T4]) begin
            case (op)
                OP_LDA, OP_ADD, OP_SUB: begin
                    cw[CW_EI] = 1'b1;
                    cw[CW_LM] = 1'b1;
                end
                OP_OUT: begin
                    cw[CW_EA] = 1'b1;
                    cw[CW_LO] = 1'b1;
                end
                default: ;
            endcase
        end
        if (t[T5]) begin
            case (op)
                OP_LDA: begin
                    cw[CW_CE] = 1'b1;
                    cw[CW_LA] = 1'b1;
                end
                OP_ADD, OP_SUB: begin
                    cw[CW_CE] = 1'b1;
                    cw[CW_LB] = 1'b1;
                end
                default: ;
            endcase
        end
        if (t[T6]) begin
            case (op)
                OP_ADD: begin
                    cw[CW_EU] = 1'b1;
                    cw[CW_LA] = 1'b1;
                end
                OP_SUB: begin
                    cw[CW_EU] = 1'b1;
                    cw[CW_SU] = 1'b1;
                    cw[CW_LA] = 1'b1;
                end
                default: ;
            endcase
        end
        return cw;
    endfunction

endpackage

// File: rtl/controller_sequencer_if.sv
// Load/enable control bus between the sequencer (master) and the register blocks (slave).
interface controller_sequencer_if;
    logic       run;
    logic [3:0] opcode;
    logic [5:0] t;
    logic       cp;
    logic       ep;
    logic       lm;
    logic       ce;
    logic       li;
    logic       ei;
    logic       la;
    logic       ea;
    logic       su;
    logic       eu;
    logic       lb;
    logic       lo;
    logic       hlt;

    modport master (
        input  run, opcode,
        output t, cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt
    );

    modport slave (
        output run, opcode,
        input  t, cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt
    );
endinterface

// File: rtl/controller_sequencer_ring_counter6.sv
// Six-state one-hot ring counter; rotates one position per enabled clock edge.
module ring_counter6 (
    input  logic       i_clk,
    input  logic       i_clr,
    input  logic       i_adv,
    output logic [5:0] o_t
);
    logic [5:0] r_t;

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_t <= 6'b000001;
        end else if (i_adv) begin
            r_t <= {r_t[4:0], r_t[5]};
        end
    end

    assign o_t = r_t;
endmodule

// File: rtl/controller_sequencer.sv
// Fetch/execute sequencer: ring counter plus control-word decode from ring state and opcode.
module controller_sequencer
    import controller_sequencer_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_clr,
    controller_sequencer_if.master ctl
);
    logic [5:0]      w_t;
    logic            w_adv;
    logic            w_hlt_step;
    logic            r_halted;
    logic [CW_W-1:0] w_cw;
    logic            w_hlt;

    ring_counter6 u_ring (
        .i_clk (i_clk),
        .i_clr (i_clr),
        .i_adv (w_adv),
        .o_t   (w_t)
    );

    // Halting holds the ring at T4; once in T2..T6 the instruction finishes regardless of run.
    assign w_hlt_step = !r_halted && w_t[T4] && (ctl.opcode == OP_HLT);
    assign w_adv      = !r_halted && !w_hlt_step && (ctl.run || !w_t[T1]);

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_halted <= 1'b0;
        end else if (w_hlt_step) begin
            r_halted <= 1'b1;
        end
    end

    // Outputs are forced idle while clr is high so reset takes effect without a clock.
    always_comb begin
        w_cw  = '0;
        w_hlt = 1'b0;
        if (!i_clr) begin
            w_hlt = r_halted || w_hlt_step;
            if (!r_halted) begin
                w_cw = cw_decode(w_t, ctl.opcode, ctl.run);
            end
        end
    end

    assign ctl.t   = w_t;
    assign ctl.cp  = w_cw[CW_CP];
    assign ctl.ep  = w_cw[CW_EP];
    assign ctl.lm  = w_cw[CW_LM];
    assign ctl.ce  = w_cw[CW_CE];
    assign ctl.li  = w_cw[CW_LI];
    assign ctl.ei  = w_cw[CW_EI];
    assign ctl.la  = w_cw[CW_LA];
    assign ctl.ea  = w_cw[CW_EA];
    assign ctl.su  = w_cw[CW_SU];
    assign ctl.eu  = w_cw[CW_EU];
    assign ctl.lb  = w_cw[CW_LB];
    assign ctl.lo  = w_cw[CW_LO];
    assign ctl.hlt = w_hlt;
endmodule
